// File: rtl/ws2812b_rx.sv
// WS2812B single-wire receiver.
// Measures each high pulse, rebuilds MSB-first 24-bit GRB pixels and spots the
// reset/latch gap. Pixels leave through a registered valid/ready output stage.
module ws2812b_rx #(
    parameter int unsigned CLOCK_MHZ     = 64,
    parameter int unsigned MIN_HIGH_NS   = 100,
    parameter int unsigned THRESH_NS     = 600,
    parameter int unsigned MAX_HIGH_NS   = 2000,
    parameter int unsigned RES_DETECT_NS = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din,
    output logic [23:0] data_out,
    output logic        latch_out,
    output logic        valid,
    input  logic        ready,
    output logic        bit_err,
    output logic        overflow
);

    // Cycle thresholds, rounded to the nearest clock and held in 16-bit counters.
    localparam int unsigned MIN_FULL = (CLOCK_MHZ * MIN_HIGH_NS + 500) / 1000;
    localparam int unsigned THR_FULL = (CLOCK_MHZ * THRESH_NS + 500) / 1000;
    localparam int unsigned MAX_FULL = (CLOCK_MHZ * MAX_HIGH_NS + 500) / 1000;
    localparam int unsigned RES_FULL = (CLOCK_MHZ * RES_DETECT_NS + 500) / 1000;

    localparam logic [15:0] MIN_CYC  = MIN_FULL[15:0];
    localparam logic [15:0] THR_CYC  = THR_FULL[15:0];
    localparam logic [15:0] MAX_CYC  = MAX_FULL[15:0];
    localparam logic [15:0] RES_CYC  = RES_FULL[15:0];
    localparam logic [15:0] HIGH_SAT = MAX_CYC + 16'd1;
    // The counter reads (cycles already spent in LOW); the gap fires in the
    // cycle that completes RES_CYC cycles of LOW.
    localparam logic [15:0] RES_M1   = RES_CYC - 16'd1;

    typedef enum logic [1:0] {
        WAIT_LOW,
        LOW,
        HIGH
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_s1;
    logic        r_s2;
    logic        r_s3;
    logic [1:0]  r_prime;

    logic [15:0] r_low_cnt;
    logic [15:0] r_high_cnt;
    logic [15:0] w_low_nxt;
    logic [15:0] w_high_nxt;

    logic [4:0]  r_bit_cnt;
    logic [22:0] r_shift;
    logic [23:0] w_shift;
    logic [23:0] r_pend_data;
    logic        r_pend;

    logic [23:0] r_data_out;
    logic        r_latch_out;
    logic        r_valid;
    logic        r_bit_err;
    logic        r_overflow;

    logic        w_rise;
    logic        w_fall;
    logic        w_primed;
    logic        w_emit;
    logic        w_emit_latch;
    logic        w_err;
    logic        w_discard;
    logic        w_bit_vld;
    logic        w_bit_val;

    assign w_rise   = r_s2 & ~r_s3;
    assign w_fall   = ~r_s2 & r_s3;
    // The synchronizer reads 0 straight out of reset regardless of the line,
    // so WAIT_LOW only trusts s2 once a real sample has reached it.
    assign w_primed = (r_prime == 2'd2);
    assign w_shift  = {r_shift, w_bit_val};

    assign data_out  = r_data_out;
    assign latch_out = r_latch_out;
    assign valid     = r_valid;
    assign bit_err   = r_bit_err;
    assign overflow  = r_overflow;

    // Bring the asynchronous line into the clock domain and keep one more tap for edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= din;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Count the cycles since reset release until s2 carries a real line sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prime <= 2'd0;
        end else if (!w_primed) begin
            r_prime <= r_prime + 2'd1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= WAIT_LOW;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, pulse classification and gap detection.
    always_comb begin
        w_state_nxt  = r_state;
        w_emit       = 1'b0;
        w_emit_latch = 1'b0;
        w_err        = 1'b0;
        w_discard    = 1'b0;
        w_bit_vld    = 1'b0;
        w_bit_val    = 1'b0;
        w_low_nxt    = (r_low_cnt == 16'hFFFF) ? r_low_cnt : r_low_cnt + 16'd1;
        w_high_nxt   = r_high_cnt;

        case (r_state)
            WAIT_LOW: begin
                if (w_primed && !r_s2) begin
                    w_state_nxt = LOW;
                    w_low_nxt   = 16'd0;
                end
            end

            LOW: begin
                if (w_rise) begin
                    // The rise cycle is the first high cycle of the pulse.
                    w_state_nxt = HIGH;
                    w_high_nxt  = 16'd1;
                    if (r_pend) begin
                        w_emit = 1'b1;
                    end
                end else if (r_low_cnt == RES_M1) begin
                    if (r_bit_cnt != 5'd0) begin
                        w_err     = 1'b1;
                        w_discard = 1'b1;
                    end
                    if (r_pend) begin
                        w_emit       = 1'b1;
                        w_emit_latch = 1'b1;
                    end
                end
            end

            HIGH: begin
                if (r_s2 && (r_high_cnt != HIGH_SAT)) begin
                    w_high_nxt = r_high_cnt + 16'd1;
                end
                if (w_fall) begin
                    w_state_nxt = LOW;
                    w_low_nxt   = 16'd0;
                    if ((r_high_cnt < MIN_CYC) || (r_high_cnt > MAX_CYC)) begin
                        w_err     = 1'b1;
                        w_discard = 1'b1;
                    end else begin
                        w_bit_vld = 1'b1;
                        w_bit_val = (r_high_cnt >= THR_CYC);
                    end
                end
            end

            default: begin
                w_state_nxt = WAIT_LOW;
            end
        endcase
    end

    // Low-period and high-pulse width counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_low_cnt  <= 16'd0;
            r_high_cnt <= 16'd0;
        end else begin
            r_low_cnt  <= w_low_nxt;
            r_high_cnt <= w_high_nxt;
        end
    end

    // Bit counter and pending flag; a discard only touches the partial pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt <= 5'd0;
            r_pend    <= 1'b0;
        end else begin
            if (w_emit) begin
                r_pend <= 1'b0;
            end
            if (w_discard) begin
                r_bit_cnt <= 5'd0;
            end else if (w_bit_vld) begin
                if (r_bit_cnt == 5'd23) begin
                    r_bit_cnt <= 5'd0;
                    r_pend    <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 5'd1;
                end
            end
        end
    end

    // Pixel shift register and pending word; pure data, qualified by the counters above.
    always_ff @(posedge clk) begin
        if (w_bit_vld) begin
            r_shift <= w_shift[22:0];
            if (r_bit_cnt == 5'd23) begin
                r_pend_data <= w_shift;
            end
        end
    end

    // Output stage: load on emit when free or being drained, else drop and flag overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out  <= 24'd0;
            r_latch_out <= 1'b0;
            r_valid     <= 1'b0;
            r_bit_err   <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_bit_err <= w_err;
            if (w_emit) begin
                if (!r_valid || ready) begin
                    r_data_out  <= r_pend_data;
                    r_latch_out <= w_emit_latch;
                    r_valid     <= 1'b1;
                end else begin
                    r_overflow <= 1'b1;
                end
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule
